// File: rtl/adder_seq32.sv
// 32-bit add/subtract built from one 8-bit full adder reused over four byte cycles, LSB first.
// Define ADDER_SEQ32_SUB_EN to build in subtraction (A-B); otherwise sub_i is ignored.

module fulladder8bits (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] sum,
  output logic       co
);
  assign {co, sum} = {1'b0, a} + {1'b0, b} + {8'd0, ci};
endmodule

// state | meaning
// IDLE  | waiting for start_i
// RUN   | one byte per cycle, byte index 0..3
// DONE  | result valid, done_o high; start_i here restarts without an idle cycle
module adder_seq32 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        c_i,
  input  logic        sub_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] res_o,
  output logic        c_o,
  output logic        ovf_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        ci_q;
  logic [1:0]  idx;
  logic        carry_q;
  logic [23:0] acc;
  logic        accept;

  logic [7:0]  a_byte;
  logic [7:0]  b_byte;
  logic [7:0]  sum;
  logic        cin;
  logic        cout;
  logic        cin0;

`ifdef ADDER_SEQ32_SUB_EN
  logic sub_q;
`else
  logic unused_sub;
  assign unused_sub = sub_i;
`endif

  assign accept = start_i && (state != RUN);

  always_comb begin
    a_byte = a_q[{idx, 3'b000} +: 8];
`ifdef ADDER_SEQ32_SUB_EN
    // Two's-complement subtract: invert B and force byte-0 carry-in to 1.
    b_byte = b_q[{idx, 3'b000} +: 8] ^ {8{sub_q}};
    cin0   = sub_q | ci_q;
`else
    b_byte = b_q[{idx, 3'b000} +: 8];
    cin0   = ci_q;
`endif
    cin = (idx == 2'd0) ? cin0 : carry_q;
  end

  fulladder8bits u_fa (
    .a   (a_byte),
    .b   (b_byte),
    .ci  (cin),
    .sum (sum),
    .co  (cout)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ci_q    <= 1'b0;
      idx     <= '0;
      carry_q <= 1'b0;
      acc     <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      res_o   <= '0;
      c_o     <= 1'b0;
      ovf_o   <= 1'b0;
`ifdef ADDER_SEQ32_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            state  <= RUN;
            busy_o <= 1'b1;
          end
        end
        RUN: begin
          carry_q <= cout;
          acc     <= {sum, acc[23:8]};
          idx     <= idx + 2'd1;
          if (idx == 2'd3) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            res_o  <= {sum, acc};
            c_o    <= cout;
            // Byte 3 carries the sign bits of A, B' and the result.
            ovf_o  <= (a_byte[7] == b_byte[7]) && (sum[7] != a_byte[7]);
          end
        end
        DONE: begin
          done_o <= 1'b0;
          if (start_i) begin
            state  <= RUN;
            busy_o <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase

      if (accept) begin
        a_q     <= a_i;
        b_q     <= b_i;
        ci_q    <= c_i;
        idx     <= '0;
        carry_q <= 1'b0;
`ifdef ADDER_SEQ32_SUB_EN
        sub_q   <= sub_i;
`endif
      end
    end
  end
endmodule

// File: doc/adder_seq32.md
ADDER_SEQ32 -- requirements
Module: adder_seq32

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk_i  input  1  clock; all state changes on its rising edge.
REQ-003 rst_i  input  1  synchronous active-high reset.
REQ-004 start_i  input  1  request; sampled only when not busy.
REQ-005 a_i  input  32  operand A; latched when start is accepted.
REQ-006 b_i  input  32  operand B; latched when start is accepted.
REQ-007 c_i  input  1  carry-in; latched when start is accepted.
REQ-008 sub_i  input  1  1 = A-B, 0 = A+B; latched when start is accepted.
REQ-009 busy_o  output  1  high while an operation is in progress.
REQ-010 done_o  output  1  one-cycle completion pulse.
REQ-011 res_o  output  32  result of the last completed operation.
REQ-012 c_o  output  1  carry-out of the last completed operation.
REQ-013 ovf_o  output  1  signed overflow of the last completed operation.

Function
REQ-014 Exactly one fulladder8bits instance SHALL be used, time-shared over four byte cycles, LSB byte first.
REQ-015 FSM states: IDLE, RUN, DONE.
- IDLE->RUN on start_i.
- RUN lasts exactly 4 cycles, using byte index 0..3.
- RUN->DONE after byte 3.
- DONE->RUN on start_i, else DONE->IDLE.
REQ-016 start_i SHALL be accepted only in IDLE or DONE; it is ignored while in RUN.
REQ-017 Operands, c_i and sub_i SHALL be registered on acceptance; later input changes SHALL NOT affect the operation in progress.
REQ-018 Byte 0 carry-in SHALL be c_i (add) or 1 (sub). Byte k>0 carry-in SHALL be the registered carry-out of byte k-1.
REQ-019 For sub, the B byte fed to the adder SHALL be bitwise inverted; c_i SHALL be ignored.
REQ-020 busy_o SHALL be high exactly during the 4 RUN cycles.
REQ-021 done_o SHALL be high for exactly the single DONE cycle.
REQ-022 Latency: start accepted at edge n -> done_o high in the cycle after edge n+4.
REQ-023 res_o, c_o and ovf_o SHALL update only on the edge entering DONE, and hold until the next completion.
REQ-024 c_o SHALL be the byte-3 carry-out; for sub, 1 means no borrow.
REQ-025 ovf_o = (A[31] == B'[31]) && (res[31] != A[31]), where B' is B as fed to the adder (inverted for sub).
REQ-026 Back-to-back operation: start_i in the DONE cycle SHALL begin a new RUN with no idle cycle.

Reset
REQ-027 rst_i high at an edge SHALL force IDLE and clear to 0: busy_o, done_o, res_o, c_o, ovf_o, the byte index, the carry register and the operand registers.
REQ-028 Reset mid-RUN SHALL abort the operation with no done_o pulse; reset has priority over start_i.

Configuration
REQ-029 Macro ADDER_SEQ32_SUB_EN.
- Defined: subtraction per REQ-019.
- Undefined: sub_i is ignored, every operation is A+B+c_i, and the subtract logic is absent.

Verification
REQ-030 A=0x000000FF, B=0x00000001, c_i=0, add -> res_o=0x00000100, c_o=0, ovf_o=0; done_o 5 cycles after start; busy_o high 4 cycles.
REQ-031 A=0xFFFFFFFF, B=0x00000001, add -> res_o=0x00000000, c_o=1, ovf_o=0; A=0x7FFFFFFF, B=1 -> res_o=0x80000000, ovf_o=1.
REQ-032 With SUB_EN: A=5, B=7, sub_i=1, c_i=1 -> res_o=0xFFFFFFFE, c_o=0, ovf_o=0. Without SUB_EN, the same stimulus -> res_o=0x0000000D.
REQ-033 start_i pulsed during RUN with different operands -> ignored; result is unchanged. start_i in the DONE cycle -> busy_o high on the next cycle, second result correct.
REQ-034 rst_i asserted in the 3rd RUN cycle -> next cycle busy_o=0, done_o=0, res_o=0; no done_o pulse follows; a subsequent start completes normally.
